// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: PC-driven instruction fetch with req/gnt/rvalid memory port and a {pc, inst} FIFO to decode.
// Define IFQ_BYPASS_EN to forward a returning word straight to decode when the FIFO is empty.
module instr_fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h00400000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect_i,
  input  logic [ADDR_W-1:0]        redirect_pc_i,
  output logic                     imem_req_o,
  output logic [ADDR_W-1:0]        imem_addr_o,
  input  logic                     imem_gnt_i,
  input  logic                     imem_rvalid_i,
  input  logic [DATA_W-1:0]        imem_rdata_i,
  output logic                     inst_valid_o,
  output logic [DATA_W-1:0]        inst_o,
  output logic [ADDR_W-1:0]        inst_pc_o,
  input  logic                     inst_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DRAIN} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] fetch_pc, req_addr;
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [ADDR_W-1:0] mem_a [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic hold, gnt_ok, rsp, byp, push, pop, empty;
  assign count_o = count;
  assign imem_addr_o = fetch_pc;
  assign empty = count == '0;
  assign gnt_ok = imem_req_o && imem_gnt_i;
  assign rsp = state == S_WAIT && imem_rvalid_i && !redirect_i;
  assign push = rsp && !(byp && inst_ready_i);
  assign pop = !empty && inst_ready_i && !redirect_i;
`ifdef IFQ_BYPASS_EN
  assign byp = empty && rsp;
  assign inst_valid_o = !empty || byp;
  assign inst_o = byp ? imem_rdata_i : mem_d[rd_ptr];
  assign inst_pc_o = byp ? req_addr : mem_a[rd_ptr];
`else
  assign byp = 1'b0;
  assign inst_valid_o = !empty;
  assign inst_o = mem_d[rd_ptr];
  assign inst_pc_o = mem_a[rd_ptr];
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_FETCH;
    else state <= state_n;
  // a redirect turns any response still owed into one that must be discarded
  always_comb
    state_n = redirect_i ? ((gnt_ok || (state != S_FETCH && !imem_rvalid_i)) ? S_DRAIN : S_FETCH) :
              state == S_FETCH ? (gnt_ok ? S_WAIT : S_FETCH) :
              imem_rvalid_i ? S_FETCH : state;
  // hold masks the request for one cycle after reset release or a redirect
  always_comb
    imem_req_o = state == S_FETCH && !hold && count < FULL;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      hold <= 1'b1;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      hold <= redirect_i;
      fetch_pc <= redirect_i ? (redirect_pc_i & ~ADDR_W'(3)) : gnt_ok ? fetch_pc + ADDR_W'(4) : fetch_pc;
      if (gnt_ok) req_addr <= fetch_pc;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] <= '0;
        mem_a[i] <= '0;
      end
    end else if (redirect_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr] <= imem_rdata_i;
        mem_a[wr_ptr] <= req_addr;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed scenarios with a scoreboard of expected {pc, inst} pops checked by a separate monitor.
module tb_instr_fetch_queue;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 0, reset = 0, redirect_i = 0, imem_rvalid_i = 0, inst_ready_i = 0;
  logic [31:0] redirect_pc_i = 0, imem_rdata_i = 0;
  logic imem_req_o, imem_gnt_i, inst_valid_o;
  logic [31:0] imem_addr_o, inst_o, inst_pc_o;
  logic [2:0] count_o;
  bit gnt_en = 0;
  int lat = 1, wait_cnt = 0, ngrants = 0, npops = 0, checks = 0, fails = 0;
  logic seen_gnt = 0;
  logic [31:0] seen_addr = 0, pend_addr = 0;
  typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;
  ent_t expq[$];
  assign imem_gnt_i = gnt_en;
  always #5 clk = ~clk;
  instr_fetch_queue dut (
    .clk(clk), .reset(reset), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .inst_valid_o(inst_valid_o),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_ready_i(inst_ready_i), .count_o(count_o)
  );
  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a == 32'h00400000 ? 32'h20080005 : {a[15:0], 16'hCAFE};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic push_seq(input logic [31:0] pc, input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = pc + 32'(4 * i);
      expq.push_back('{a, mdata(a)});
    end
  endtask
  task automatic posp();
    @(posedge clk);
    #1;
  endtask
  task automatic negp();
    @(negedge clk);
  endtask
  task automatic do_redirect(input logic [31:0] pc, input int n);
    redirect_i = 1;
    redirect_pc_i = pc;
    posp();
    redirect_i = 0;
    expq.delete();
    push_seq({pc[31:2], 2'b00}, n);
    ngrants = 0;
  endtask
  task automatic chk_reset(input string tag);
    check({tag, "_req"}, imem_req_o, 0);
    check({tag, "_count"}, count_o, 0);
    check({tag, "_valid"}, inst_valid_o, 0);
    check({tag, "_inst"}, inst_o, 0);
    check({tag, "_pc"}, inst_pc_o, 0);
    check({tag, "_addr"}, imem_addr_o, 32'h00400000);
  endtask
  // memory model: one outstanding read, rvalid lat cycles after the grant edge
  always @(negedge clk) begin
    seen_gnt = imem_req_o && imem_gnt_i;
    seen_addr = imem_addr_o;
    if (seen_gnt) ngrants++;
  end
  always @(posedge clk) begin
    #1;
    imem_rvalid_i = 0;
    if (seen_gnt) begin
      pend_addr = seen_addr;
      wait_cnt = lat;
    end
    if (wait_cnt > 0) begin
      wait_cnt--;
      if (wait_cnt == 0) begin
        imem_rvalid_i = 1;
        imem_rdata_i = mdata(pend_addr);
      end
    end
  end
  always @(negedge clk)
    if (reset && inst_valid_o && inst_ready_i && !redirect_i) begin
      npops++;
      if (expq.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_pop: got pc %h, none expected", inst_pc_o);
      end else begin
        ent_t e;
        e = expq.pop_front();
        check("pop_pc", inst_pc_o, e.pc);
        check("pop_inst", inst_o, e.inst);
      end
    end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int p0;
    bit found;
    repeat (2) negp();
    chk_reset("rst");
    // T1: first fetch after reset release
    posp();
    reset = 1;
    inst_ready_i = 1;
    gnt_en = 1;
    push_seq(32'h00400000, 12);
    negp();
    check("t1_hold_req", imem_req_o, 0);
    negp();
    check("t1_req", imem_req_o, 1);
    check("t1_addr", imem_addr_o, 32'h00400000);
    negp();
    check("t1_wait_req", imem_req_o, 0);
    check("t1_latency_valid", inst_valid_o, BYP);
    negp();
    check("t1_req2", imem_req_o, 1);
    check("t1_addr2", imem_addr_o, 32'h00400004);
    check("t1_count", count_o, BYP ? 0 : 1);
    repeat (10) negp();
    check("t1_pops", npops >= 4, 1);
    // T2: fill with decode stalled
    posp();
    inst_ready_i = 0;
    do_redirect(32'h00400200, 8);
    repeat (20) negp();
    check("t2_grants", ngrants, 4);
    check("t2_count", count_o, 4);
    check("t2_req", imem_req_o, 0);
    check("t2_valid", inst_valid_o, 1);
    check("t2_head_pc", inst_pc_o, 32'h00400200);
    p0 = npops;
    posp();
    inst_ready_i = 1;
    posp();
    inst_ready_i = 0;
    repeat (10) negp();
    check("t2_one_pop", npops - p0, 1);
    check("t2_grants_after", ngrants, 5);
    check("t2_count_after", count_o, 4);
    // T3: redirect while waiting for data
    posp();
    gnt_en = 0;
    lat = 2;
    do_redirect(32'h00400300, 0);
    negp();
    check("t3_hold_req", imem_req_o, 0);
    negp();
    check("t3_req", imem_req_o, 1);
    check("t3_addr", imem_addr_o, 32'h00400300);
    posp();
    gnt_en = 1;
    negp();
    posp();
    gnt_en = 0;
    redirect_i = 1;
    redirect_pc_i = 32'h00400103;
    negp();
    check("t3_wait_req", imem_req_o, 0);
    posp();
    redirect_i = 0;
    expq.delete();
    push_seq(32'h00400100, 8);
    negp();
    check("t3_drain_count", count_o, 0);
    check("t3_drain_valid", inst_valid_o, 0);
    check("t3_drain_req", imem_req_o, 0);
    negp();
    check("t3_new_req", imem_req_o, 1);
    check("t3_new_addr", imem_addr_o, 32'h00400100);
    check("t3_new_count", count_o, 0);
    posp();
    lat = 1;
    gnt_en = 1;
    inst_ready_i = 1;
    p0 = npops;
    repeat (8) negp();
    check("t3_pops", npops - p0 >= 2, 1);
    // T4: redirect coinciding with a push and a pop at count 2
    posp();
    inst_ready_i = 0;
    do_redirect(32'h00400400, 0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      negp();
      #1;
      found = count_o == 2 && imem_rvalid_i;
    end
    check("t4_reached", found, 1);
    redirect_i = 1;
    redirect_pc_i = 32'h00400500;
    inst_ready_i = 1;
    posp();
    redirect_i = 0;
    expq.delete();
    push_seq(32'h00400500, 8);
    negp();
    check("t4_count", count_o, 0);
    check("t4_valid", inst_valid_o, 0);
    p0 = npops;
    repeat (10) negp();
    check("t4_pops", npops - p0 >= 3, 1);
    // T5: fetch PC wraps at the top of the address space
    posp();
    do_redirect(32'hFFFFFFFC, 6);
    negp();
    check("t5_hold_req", imem_req_o, 0);
    negp();
    check("t5_addr_top", imem_addr_o, 32'hFFFFFFFC);
    negp();
    negp();
    check("t5_req_wrap", imem_req_o, 1);
    check("t5_addr_wrap", imem_addr_o, 32'h00000000);
    repeat (4) negp();
    // T6: asynchronous reset while a read is outstanding
    posp();
    inst_ready_i = 0;
    lat = 2;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      negp();
      found = imem_req_o && imem_gnt_i;
    end
    check("t6_grant_seen", found, 1);
    @(posedge clk);
    #3;
    reset = 0;
    #1;
    chk_reset("t6_async");
    #4;
    reset = 1;
    expq.delete();
    push_seq(32'h00400000, 8);
    negp();
    check("t6_req", imem_req_o, 1);
    check("t6_addr", imem_addr_o, 32'h00400000);
    check("t6_count", count_o, 0);
    negp();
    check("t6_stale_ignored", count_o, 0);
    check("t6_wait_req", imem_req_o, 0);
    posp();
    inst_ready_i = 1;
    negp();
    check("t6_bypass_valid", inst_valid_o, BYP);
    check("t6_bypass_count", count_o, 0);
    p0 = npops;
    repeat (10) negp();
    check("t6_pops", npops - p0 >= 2, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
